// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Width macros default here when no def.h has defined them first.
`ifndef IMEM_ADDR_W
`define IMEM_ADDR_W 5
`endif
`ifndef INST_W
`define INST_W 32
`endif

package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BYTES_PER_INST = 4;

endpackage

// File: rtl/imem_loader.sv
// Assembles a little-endian byte stream into instructions, writes them from
// address 0 upward, and holds the core in reset until the load finishes.
module imem_loader #(
    parameter int IMEM_ADDR_W = `IMEM_ADDR_W,
    parameter int INST_W      = `INST_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [IMEM_ADDR_W:0]   word_count,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_waddr,
    output logic [INST_W-1:0]      imem_wdata,
    output logic                   core_reset_n,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    import imem_loader_pkg::*;

    localparam logic [IMEM_ADDR_W:0] DEPTH     = (IMEM_ADDR_W+1)'(2**IMEM_ADDR_W);
    localparam logic [IMEM_ADDR_W:0] COUNT_ONE = (IMEM_ADDR_W+1)'(1);
    localparam logic [1:0]           LAST_BYTE = 2'(BYTES_PER_INST - 1);

    state_t                 state_q, state_d;
    logic [IMEM_ADDR_W:0]   count_q;
    logic [IMEM_ADDR_W-1:0] addr_q;
    logic [1:0]             byte_idx_q;
    logic [INST_W-1:0]      word_q;
    logic                   err_q;
    logic                   released_q;

    logic count_ok;
    logic last_word;

    assign count_ok  = (word_count != '0) && (word_count <= DEPTH);
    assign last_word = ({1'b0, addr_q} == (count_q - COUNT_ONE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start && count_ok) state_d = RECV;
            RECV:  if (byte_valid && (byte_idx_q == LAST_BYTE)) state_d = WRITE;
            WRITE: state_d = last_word ? DONE : RECV;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
            released_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == IDLE) && start && !count_ok;
            case (state_q)
                IDLE: begin
                    if (start && count_ok) begin
                        count_q    <= word_count;
                        addr_q     <= '0;
                        byte_idx_q <= '0;
                        released_q <= 1'b0;
                    end
                end
                RECV: begin
                    // Shift in from the top so byte 0 lands in bits [7:0] after four bytes.
                    if (byte_valid) begin
                        word_q     <= {byte_data, word_q[INST_W-1:8]};
                        byte_idx_q <= byte_idx_q + 2'd1;
                    end
                end
                WRITE: begin
                    if (!last_word) begin
                        addr_q     <= addr_q + IMEM_ADDR_W'(1);
                        byte_idx_q <= '0;
                    end
                end
                DONE: released_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Outputs decode from registered state only.
    assign byte_ready   = (state_q == RECV);
    assign imem_we      = (state_q == WRITE);
    assign imem_waddr   = addr_q;
    assign imem_wdata   = word_q;
    assign core_reset_n = released_q || (state_q == DONE);
    assign busy         = (state_q == RECV) || (state_q == WRITE);
    assign done         = (state_q == DONE);
    assign err          = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, back-to-back and stalled loads,
// rejected counts, full fill, and reset in the middle of a load.
module tb_imem_loader;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_reset_n;
    logic          busy;
    logic          done;
    logic          err;

    imem_loader #(.IMEM_ADDR_W(AW), .INST_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .word_count   (word_count),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_reset_n (core_reset_n),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stream [0:127];
    int          nbytes;
    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cycle[$];
    int          done_cycle;
    logic        core_at_done;
    logic        busy_at_done;
    int          core_bad;
    int          busy_bad;
    int          err_seen;

    function automatic logic [42:0] outs();
        return {byte_ready, imem_we, imem_waddr, imem_wdata, core_reset_n, busy, done, err};
    endfunction

    function automatic logic [31:0] exp_word(input int k);
        return {stream[4*k+3], stream[4*k+2], stream[4*k+1], stream[4*k]};
    endfunction

    task automatic load_b2b_stream();
        stream[0] = 8'h13; stream[1] = 8'h05; stream[2] = 8'h10; stream[3] = 8'h00;
        stream[4] = 8'hB3; stream[5] = 8'h05; stream[6] = 8'hB5; stream[7] = 8'h00;
        nbytes = 8;
    endtask

    // Start accepted at edge 0; loop index c is the cycle number observed #1 after edge c-1.
    task automatic do_load(input int n, input bit stall, input int start_cycle, input int max_cycles);
        int   ptr;
        logic pv, pr;
        ptr = 0; pv = 1'b0; pr = 1'b0;
        wr_addr.delete(); wr_data.delete(); wr_cycle.delete();
        done_cycle = -1; core_at_done = 1'b0; busy_at_done = 1'b1;
        core_bad = 0; busy_bad = 0; err_seen = 0;
        @(posedge clk); #1;
        start = 1'b1; word_count = (AW+1)'(n); byte_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= max_cycles; c++) begin
            if (pv && pr) ptr++;
            if (err) err_seen++;
            if (imem_we) begin
                wr_addr.push_back(int'(imem_waddr));
                wr_data.push_back(imem_wdata);
                wr_cycle.push_back(c);
            end
            if (done) begin
                done_cycle = c; core_at_done = core_reset_n; busy_at_done = busy;
                break;
            end
            if (core_reset_n !== 1'b0) core_bad++;
            if (busy !== 1'b1) busy_bad++;
            start      = (c == start_cycle);
            byte_valid = stall ? (c % 2 == 1) : 1'b1;
            byte_data  = (ptr < nbytes) ? stream[ptr] : 8'h00;
            pv = byte_valid; pr = byte_ready;
            @(posedge clk); #1;
        end
        if (done_cycle >= 0) begin
            start = 1'b0; byte_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        int bad;
        #1;
        checks++;
        if (outs() !== 43'd0) begin errors++; $display("FAIL reset_async outs=%h want 0", outs()); end
        @(posedge clk); #1;
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (outs() !== 43'd0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_idle nonzero_cycles=%0d want 0", bad); end
        checks++;
        if (core_reset_n !== 1'b0) begin errors++; $display("FAIL reset_core core_reset_n=%b want 0", core_reset_n); end
    endtask

    task automatic test_back_to_back();
        load_b2b_stream();
        do_load(2, 1'b0, -1, 40);
        checks++;
        if (wr_data.size() != 2) begin errors++; $display("FAIL b2b_nwrites got=%0d want 2", wr_data.size()); end
        if (wr_data.size() >= 2) begin
            checks++;
            if (wr_addr[0] != 0 || wr_data[0] !== 32'h00100513 || wr_cycle[0] != 5) begin
                errors++; $display("FAIL b2b_w0 addr=%0d data=%h cyc=%0d want 0 00100513 5", wr_addr[0], wr_data[0], wr_cycle[0]);
            end
            checks++;
            if (wr_addr[1] != 1 || wr_data[1] !== 32'h00B505B3 || wr_cycle[1] != 10) begin
                errors++; $display("FAIL b2b_w1 addr=%0d data=%h cyc=%0d want 1 00b505b3 10", wr_addr[1], wr_data[1], wr_cycle[1]);
            end
        end
        checks++;
        if (done_cycle != 11 || core_at_done !== 1'b1 || busy_at_done !== 1'b0) begin
            errors++; $display("FAIL b2b_done cyc=%0d core=%b busy=%b want 11 1 0", done_cycle, core_at_done, busy_at_done);
        end
        checks++;
        if (core_bad != 0 || busy_bad != 0) begin
            errors++; $display("FAIL b2b_hold core_high=%0d busy_low=%0d want 0 0", core_bad, busy_bad);
        end
        @(posedge clk); #1;
        checks++;
        if (core_reset_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_after core=%b busy=%b done=%b rdy=%b want 1 0 0 0", core_reset_n, busy, done, byte_ready);
        end
    endtask

    task automatic test_stall();
        load_b2b_stream();
        do_load(2, 1'b1, -1, 60);
        checks++;
        if (wr_data.size() != 2) begin errors++; $display("FAIL stall_nwrites got=%0d want 2", wr_data.size()); end
        if (wr_data.size() >= 2) begin
            checks++;
            if (wr_addr[0] != 0 || wr_data[0] !== 32'h00100513 || wr_cycle[0] != 8) begin
                errors++; $display("FAIL stall_w0 addr=%0d data=%h cyc=%0d want 0 00100513 8", wr_addr[0], wr_data[0], wr_cycle[0]);
            end
            checks++;
            if (wr_addr[1] != 1 || wr_data[1] !== 32'h00B505B3 || wr_cycle[1] != 16) begin
                errors++; $display("FAIL stall_w1 addr=%0d data=%h cyc=%0d want 1 00b505b3 16", wr_addr[1], wr_data[1], wr_cycle[1]);
            end
        end
        checks++;
        if (done_cycle != 17 || core_at_done !== 1'b1) begin
            errors++; $display("FAIL stall_done cyc=%0d core=%b want 17 1", done_cycle, core_at_done);
        end
    endtask

    task automatic test_reject();
        logic [AW:0] bad_counts [0:1];
        bad_counts[0] = 6'd0;
        bad_counts[1] = 6'd33;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            start = 1'b1; word_count = bad_counts[i];
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || imem_we !== 1'b0 || core_reset_n !== 1'b1) begin
                errors++; $display("FAIL reject_%0d err=%b busy=%b we=%b core=%b want 1 0 0 1", bad_counts[i], err, busy, imem_we, core_reset_n);
            end
            @(posedge clk); #1;
            checks++;
            if (err !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0 || imem_we !== 1'b0) begin
                errors++; $display("FAIL reject_%0d_after err=%b busy=%b rdy=%b we=%b want 0 0 0 0", bad_counts[i], err, busy, byte_ready, imem_we);
            end
        end
    endtask

    task automatic test_full_fill();
        int bad;
        for (int i = 0; i < 128; i++) stream[i] = 8'((i * 37 + 11) % 256);
        nbytes = 128;
        do_load(32, 1'b0, 50, 200);
        checks++;
        if (wr_data.size() != 32) begin errors++; $display("FAIL full_nwrites got=%0d want 32", wr_data.size()); end
        bad = 0;
        for (int k = 0; k < wr_data.size() && k < 32; k++) begin
            checks++;
            if (wr_addr[k] != k || wr_data[k] !== exp_word(k) || wr_cycle[k] != 5 * k + 5) begin
                errors++; bad++;
                if (bad < 4) $display("FAIL full_w%0d addr=%0d data=%h cyc=%0d want %0d %h %0d",
                                      k, wr_addr[k], wr_data[k], wr_cycle[k], k, exp_word(k), 5 * k + 5);
            end
        end
        checks++;
        if (done_cycle != 161) begin errors++; $display("FAIL full_done cyc=%0d want 161", done_cycle); end
        checks++;
        if (err_seen != 0 || core_bad != 0 || busy_bad != 0) begin
            errors++; $display("FAIL full_ctrl err=%0d core_high=%0d busy_low=%0d want 0 0 0", err_seen, core_bad, busy_bad);
        end
    endtask

    task automatic test_reset_midload();
        load_b2b_stream();
        do_load(2, 1'b0, -1, 6);
        checks++;
        if (byte_ready !== 1'b1 || busy !== 1'b1 || wr_data.size() != 1) begin
            errors++; $display("FAIL mid_pre rdy=%b busy=%b nwr=%0d want 1 1 1", byte_ready, busy, wr_data.size());
        end
        reset = 1'b0;
        byte_valid = 1'b0;
        #1;
        checks++;
        if (outs() !== 43'd0) begin errors++; $display("FAIL mid_reset outs=%h want 0", outs()); end
        @(posedge clk); #1;
        reset = 1'b1;
        do_load(2, 1'b0, -1, 40);
        checks++;
        if (wr_data.size() < 1) begin
            errors++; $display("FAIL mid_restart nwrites=0 want 2");
        end else if (wr_addr[0] != 0 || wr_data[0] !== 32'h00100513 || wr_cycle[0] != 5) begin
            errors++; $display("FAIL mid_restart addr=%0d data=%h cyc=%0d want 0 00100513 5", wr_addr[0], wr_data[0], wr_cycle[0]);
        end
        checks++;
        if (done_cycle != 11) begin errors++; $display("FAIL mid_done cyc=%0d want 11", done_cycle); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_reject();
        test_full_fill();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
